// File: rtl/hps_ring_readpointer_ctrl_if.sv
// Avalon-MM slave bus bundle for the ring-buffer read-pointer controller
// (3-bit word address, 32-bit data, read latency 1).
interface hps_ring_readpointer_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, read_n, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, read_n, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/hps_ring_readpointer_ctrl.sv
// Consumer read-pointer owner for an FPGA ring buffer: modulo advance, fill level, threshold irq.
// Define HPS_RDPTR_GRAY_OUT_EN to drive out_port as Gray code (requires DEPTH == 2**PTR_W).
module hps_ring_readpointer_ctrl #(
  parameter int PTR_W   = 9,
  parameter int DEPTH   = 512,
  parameter bit IRQ_RST = 1'b0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  hps_ring_readpointer_ctrl_if.slave   bus,
  input  logic [PTR_W-1:0]             wr_ptr_in,
  output logic [PTR_W-1:0]             out_port,
  output logic                         irq
);

  localparam logic [PTR_W:0] DEPTH_X = (PTR_W+1)'(DEPTH);

`ifdef HPS_RDPTR_GRAY_OUT_EN
  if (DEPTH != (1 << PTR_W)) begin : g_depth_check
    $error("Gray out_port requires DEPTH == 2**PTR_W");
  end
`endif

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] thresh_q, thresh_d;
  logic [PTR_W-1:0] out_q, out_d;
  logic             irq_en_q, irq_en_d;
  logic             overrun_q, overrun_d;
  logic             bad_ptr_q, bad_ptr_d;
  logic             irq_q, irq_d;
  logic [31:0]      readdata_q, readdata_d;

  logic             wr_en, rd_en;
  logic [PTR_W:0]   rd_x, wr_x, fill;
  logic [PTR_W:0]   adv_n, adv_sum, adv_wrap;
  logic             irq_pend;
  logic             ptr_ok;
  logic [31:0]      rd_mux;

  assign wr_en = bus.chipselect & ~bus.write_n;
  assign rd_en = bus.chipselect & ~bus.read_n;

  // Fill is computed one bit wider than the pointers so the wrap term cannot overflow.
  always_comb begin
    rd_x     = {1'b0, rd_ptr_q};
    wr_x     = {1'b0, wr_q};
    fill     = (wr_x >= rd_x) ? (wr_x - rd_x) : (wr_x + DEPTH_X - rd_x);
    irq_pend = (fill >= {1'b0, thresh_q}) && (fill != '0);
    adv_n    = bus.writedata[PTR_W:0];
    adv_sum  = rd_x + adv_n;
    adv_wrap = adv_sum - DEPTH_X;
    ptr_ok   = ((bus.writedata >> PTR_W) == 32'd0) &&
               ({1'b0, bus.writedata[PTR_W-1:0]} < DEPTH_X);
  end

  always_comb begin
    rd_mux = 32'd0;
    case (bus.address)
      3'd0:    rd_mux = 32'(rd_ptr_q);
      3'd1:    rd_mux = 32'(wr_q);
      3'd2:    rd_mux = 32'(fill);
      3'd4:    rd_mux = 32'(thresh_q);
      3'd5:    rd_mux = {28'd0, irq_pend, bad_ptr_q, overrun_q, irq_en_q};
      default: rd_mux = 32'd0;
    endcase
  end

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_d       = wr_ptr_in;
    thresh_d   = thresh_q;
    irq_en_d   = irq_en_q;
    overrun_d  = overrun_q;
    bad_ptr_d  = bad_ptr_q;
    readdata_d = readdata_q;

    if (wr_en) begin
      case (bus.address)
        3'd0: begin
          if (ptr_ok) rd_ptr_d  = bus.writedata[PTR_W-1:0];
          else        bad_ptr_d = 1'b1;
        end
        3'd3: begin
          // An over-long advance clamps to the producer pointer sampled last cycle.
          if (adv_n <= fill) begin
            rd_ptr_d = (adv_sum >= DEPTH_X) ? adv_wrap[PTR_W-1:0] : adv_sum[PTR_W-1:0];
          end else begin
            rd_ptr_d  = wr_q;
            overrun_d = 1'b1;
          end
        end
        3'd4: thresh_d = bus.writedata[PTR_W-1:0];
        3'd5: begin
          irq_en_d = bus.writedata[0];
          if (bus.writedata[1]) overrun_d = 1'b0;
          if (bus.writedata[2]) bad_ptr_d = 1'b0;
        end
        default: ;
      endcase
    end

    if (rd_en) readdata_d = rd_mux;

    irq_d = irq_en_q && (irq_pend || overrun_q || bad_ptr_q);

`ifdef HPS_RDPTR_GRAY_OUT_EN
    out_d = rd_ptr_d ^ (rd_ptr_d >> 1);
`else
    out_d = rd_ptr_d;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q   <= '0;
      wr_q       <= '0;
      thresh_q   <= '0;
      out_q      <= '0;
      irq_en_q   <= IRQ_RST;
      overrun_q  <= 1'b0;
      bad_ptr_q  <= 1'b0;
      irq_q      <= 1'b0;
      readdata_q <= 32'd0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_q       <= wr_d;
      thresh_q   <= thresh_d;
      out_q      <= out_d;
      irq_en_q   <= irq_en_d;
      overrun_q  <= overrun_d;
      bad_ptr_q  <= bad_ptr_d;
      irq_q      <= irq_d;
      readdata_q <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign out_port     = out_q;
  assign irq          = irq_q;

endmodule
